// File: rtl/life_sequencer.sv
// Life generation sequencer: scans the 8x8 toroidal board cell by cell, writes each next state, then commits.
// state | meaning: IDLE wait enable | FETCH address cell | EVAL write result | COMMIT replace | HOLD interval
module life_sequencer #(
    parameter int unsigned GEN_INTERVAL = 16,
    parameter logic [7:0]  ALIVE_VAL    = 8'hFF,
    parameter logic [7:0]  DEAD_VAL     = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    output logic [5:0]  pixel,
    output logic [7:0]  new_pixel_value,
    output logic [1:0]  write_flag,
    input  logic [63:0] previous_line,
    input  logic [63:0] current_line,
    input  logic [63:0] next_line,
    output logic        busy,
    output logic        gen_done,
    output logic [15:0] gen_count
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_EVAL   = 3'd2;
    localparam logic [2:0] S_COMMIT = 3'd3;
    localparam logic [2:0] S_HOLD   = 3'd4;

    localparam logic [1:0] WF_IDLE    = 2'b00;
    localparam logic [1:0] WF_WRITE   = 2'b01;
    localparam logic [1:0] WF_REPLACE = 2'b10;

    localparam logic [15:0] INTERVAL = 16'(GEN_INTERVAL);

    logic [2:0]  state_q, state_d;
    logic [5:0]  pixel_q, pixel_d;
    logic [1:0]  wflag_q, wflag_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [15:0] count_q, count_d;
    logic [15:0] hold_q, hold_d;

    always_comb begin
        state_d = state_q;
        pixel_d = pixel_q;
        count_d = count_q;
        hold_d  = hold_q;
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_FETCH;
                    pixel_d = '0;
                end
            end
            S_FETCH: state_d = S_EVAL;
            S_EVAL: begin
                if (pixel_q == 6'd63) begin
                    state_d = S_COMMIT;
                    pixel_d = '0;
                end else begin
                    state_d = S_FETCH;
                    pixel_d = pixel_q + 6'd1;
                end
            end
            S_COMMIT: begin
                state_d = S_HOLD;
                hold_d  = INTERVAL;
                count_d = count_q + 16'd1;
            end
            S_HOLD: begin
                // Dropping enable always wins; the interval only gates restart.
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (hold_q == 16'd0) begin
                    state_d = S_FETCH;
                    pixel_d = '0;
                end else begin
                    hold_d = hold_q - 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                pixel_d = '0;
            end
        endcase
    end

    always_comb begin
        wflag_d = WF_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_d)
            S_FETCH: busy_d = 1'b1;
            S_EVAL: begin
                busy_d  = 1'b1;
                wflag_d = WF_WRITE;
            end
            S_COMMIT: begin
                busy_d  = 1'b1;
                wflag_d = WF_REPLACE;
                done_d  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pixel_q <= '0;
            wflag_q <= WF_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            count_q <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            pixel_q <= pixel_d;
            wflag_q <= wflag_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            count_q <= count_d;
            hold_q  <= hold_d;
        end
    end

    function automatic logic cell_live(input logic [63:0] line, input logic [2:0] col);
        return |line[{col, 3'b000} +: 8];
    endfunction

    logic [2:0] col_c, col_l, col_r;
    logic [3:0] nbr_cnt;
    logic       self_live, next_live;

    // Column neighbours wrap through the 3-bit arithmetic; row wrap is done by the memory.
    always_comb begin
        col_c     = pixel_q[2:0];
        col_l     = col_c - 3'd1;
        col_r     = col_c + 3'd1;
        nbr_cnt   = {3'b000, cell_live(previous_line, col_l)}
                  + {3'b000, cell_live(previous_line, col_c)}
                  + {3'b000, cell_live(previous_line, col_r)}
                  + {3'b000, cell_live(current_line,  col_l)}
                  + {3'b000, cell_live(current_line,  col_r)}
                  + {3'b000, cell_live(next_line,     col_l)}
                  + {3'b000, cell_live(next_line,     col_c)}
                  + {3'b000, cell_live(next_line,     col_r)};
        self_live = cell_live(current_line, col_c);
        next_live = (nbr_cnt == 4'd3) || (self_live && (nbr_cnt == 4'd2));
        new_pixel_value = ((state_q == S_EVAL) && next_live) ? ALIVE_VAL : DEAD_VAL;
    end

    assign pixel      = pixel_q;
    assign write_flag = wflag_q;
    assign busy       = busy_q;
    assign gen_done   = done_q;
    assign gen_count  = count_q;

endmodule

// File: tb/tb_life_sequencer.sv
// Bench for life_sequencer: models the double-buffered cell memory, predicts every WRITE/REPLACE
// from a plain Life reference and checks them through a scoreboard popped by a monitor.
module tb_life_sequencer;
    localparam logic [7:0] ALIVE = 8'hFF;
    localparam logic [7:0] DEAD  = 8'h00;

    typedef struct {
        logic [1:0]  flag;
        logic [5:0]  pix;
        logic [7:0]  val;
        logic [15:0] gen;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [5:0]  pixel;
    logic [7:0]  new_pixel_value;
    logic [1:0]  write_flag;
    logic [63:0] previous_line, current_line, next_line;
    logic        busy, gen_done;
    logic [15:0] gen_count;

    logic [63:0] rbuf [8];
    logic [63:0] wbuf [8];
    logic [63:0] init_rows [8];
    logic [63:0] saved_rows [8];
    exp_t        sb_q [$];
    logic [63:0] ref_grid;
    logic [63:0] saved_grid;
    logic [15:0] drv_gen = 16'd0;
    logic [15:0] cnt_expect = 16'd0;
    bit          cnt_pending = 1'b0;
    int checks = 0, errors = 0, cyc = 0, n_writes = 0, n_replaces = 0;

    life_sequencer #(.GEN_INTERVAL(0), .ALIVE_VAL(ALIVE), .DEAD_VAL(DEAD)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .pixel(pixel), .new_pixel_value(new_pixel_value), .write_flag(write_flag),
        .previous_line(previous_line), .current_line(current_line), .next_line(next_line),
        .busy(busy), .gen_done(gen_done), .gen_count(gen_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] next_gen(input logic [63:0] g);
        logic [63:0] n;
        int cnt;
        n = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if (dr != 0 || dc != 0)
                            cnt += int'(g[((r + dr + 8) % 8) * 8 + ((c + dc + 8) % 8)]);
                n[r * 8 + c] = (cnt == 3) || (g[r * 8 + c] && cnt == 2);
            end
        end
        return n;
    endfunction

    function automatic logic [63:0] row_of(input logic [63:0] g, input int r);
        logic [63:0] row;
        row = '0;
        for (int c = 0; c < 8; c++) row[c * 8 +: 8] = g[r * 8 + c] ? ALIVE : DEAD;
        return row;
    endfunction

    // Memory model: lines follow pixel half a cycle later and hold; writes and replace land mid-cycle.
    always @(negedge clk) begin
        logic [2:0] row;
        if (write_flag == 2'b01) wbuf[pixel[5:3]][pixel[2:0] * 8 +: 8] = new_pixel_value;
        else if (write_flag == 2'b10) for (int r = 0; r < 8; r++) rbuf[r] = wbuf[r];
        row           = pixel[5:3];
        previous_line = rbuf[row - 3'd1];
        current_line  = rbuf[row];
        next_line     = rbuf[row + 3'd1];
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0) begin
            if (cnt_pending) begin
                check("gen_count", 64'(gen_count), 64'(cnt_expect));
                cnt_pending = 1'b0;
            end
            if (write_flag == 2'b11) begin
                checks++;
                errors++;
                $display("FAIL write_flag_11: got 2'b11, expected 00/01/10");
            end
            if (write_flag != 2'b01) check("npv_outside_eval", 64'(new_pixel_value), 64'(DEAD));
            if (gen_done || write_flag == 2'b10)
                check("done_with_replace", 64'({gen_done, write_flag}), 64'({1'b1, 2'b10}));
            if (write_flag != 2'b00) check("busy_during_op", 64'(busy), 64'd1);
            if (busy && write_flag == 2'b00 && sb_q.size() > 0 && sb_q[0].flag == 2'b01)
                check("fetch_pixel", 64'(pixel), 64'(sb_q[0].pix));
            if (write_flag == 2'b01 || write_flag == 2'b10) begin
                if (write_flag == 2'b01) n_writes++;
                else n_replaces++;
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_op: flag=%b pixel=%0d, expected no activity", write_flag, pixel);
                end else begin
                    e = sb_q.pop_front();
                    check("op_kind", 64'(write_flag), 64'(e.flag));
                    if (e.flag == 2'b01) begin
                        check("write_pixel", 64'(pixel), 64'(e.pix));
                        check("write_value", 64'(new_pixel_value), 64'(e.val));
                    end else if (write_flag == 2'b10) begin
                        cnt_pending = 1'b1;
                        cnt_expect  = e.gen;
                    end
                end
            end
        end
    end

    task automatic load_init();
        ref_grid = '0;
        for (int r = 0; r < 8; r++) begin
            rbuf[r] = init_rows[r];
            wbuf[r] = '0;
            for (int c = 0; c < 8; c++) ref_grid[r * 8 + c] = |init_rows[r][c * 8 +: 8];
        end
    endtask

    task automatic clear_init();
        for (int r = 0; r < 8; r++) init_rows[r] = '0;
    endtask

    task automatic random_init();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                init_rows[r][c * 8 +: 8] = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
        load_init();
    endtask

    task automatic push_gen();
        logic [63:0] nxt;
        nxt = next_gen(ref_grid);
        for (int p = 0; p < 64; p++) sb_q.push_back('{2'b01, 6'(p), nxt[p] ? ALIVE : DEAD, 16'd0});
        drv_gen = drv_gen + 16'd1;
        sb_q.push_back('{2'b10, 6'd0, DEAD, drv_gen});
        ref_grid = nxt;
    endtask

    task automatic check_rows_model(input string name);
        for (int r = 0; r < 8; r++) check(name, rbuf[r], row_of(ref_grid, r));
    endtask

    task automatic run_gens(input int n, input bit timing);
        int seen, en_cyc, fetch_cyc;
        int done_cyc [$];
        for (int g = 0; g < n; g++) push_gen();
        @(negedge clk);
        enable    = 1'b1;
        en_cyc    = cyc;
        seen      = 0;
        fetch_cyc = -1;
        for (int k = 0; k < 200 * n && seen < n; k++) begin
            @(negedge clk);
            if (busy && fetch_cyc < 0) fetch_cyc = cyc;
            if (gen_done) begin
                done_cyc.push_back(cyc);
                seen++;
                if (seen == n) enable = 1'b0;
            end
        end
        enable = 1'b0;
        check("gens_completed", 64'(seen), 64'(n));
        repeat (3) @(negedge clk);
        if (timing && seen == n) begin
            check("first_fetch_delay", 64'(fetch_cyc - en_cyc), 64'd1);
            check("fetch_to_done", 64'(done_cyc[0] - fetch_cyc), 64'd128);
            if (n >= 2) check("done_period", 64'(done_cyc[1] - done_cyc[0]), 64'd130);
        end
        check_rows_model("rows_vs_model");
    endtask

    initial begin
        int found, act;
        rst    = 1'b0;
        enable = 1'b0;
        for (int r = 0; r < 8; r++) begin
            rbuf[r] = '0;
            wbuf[r] = '0;
        end
        clear_init();
        ref_grid = '0;
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_pixel", 64'(pixel), 64'd0);
        check("rst_write_flag", 64'(write_flag), 64'd0);
        check("rst_npv", 64'(new_pixel_value), 64'(DEAD));
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_gen_done", 64'(gen_done), 64'd0);
        check("rst_gen_count", 64'(gen_count), 64'd0);
        rst = 1'b0;

        // Blinker oscillates with period 2.
        clear_init();
        init_rows[3] = 64'h000000FFFFFF0000;
        load_init();
        run_gens(1, 1'b0);
        for (int r = 0; r < 8; r++)
            check("blinker_gen1", rbuf[r], (r >= 2 && r <= 4) ? 64'h00000000FF000000 : 64'h0);
        run_gens(1, 1'b0);
        for (int r = 0; r < 8; r++)
            check("blinker_gen2", rbuf[r], (r == 3) ? 64'h000000FFFFFF0000 : 64'h0);
        check("blinker_gen_count", 64'(gen_count), 64'd2);

        // Block still life over three back-to-back generations.
        clear_init();
        init_rows[2] = 64'h0000000000FFFF00;
        init_rows[3] = 64'h0000000000FFFF00;
        load_init();
        n_writes   = 0;
        n_replaces = 0;
        run_gens(3, 1'b1);
        check("block_writes", 64'(n_writes), 64'd192);
        check("block_replaces", 64'(n_replaces), 64'd3);
        for (int r = 0; r < 8; r++)
            check("block_rows", rbuf[r], (r == 2 || r == 3) ? 64'h0000000000FFFF00 : 64'h0);

        // Horizontal blinker across the column wrap at row 0, columns 7, 0, 1.
        clear_init();
        init_rows[0] = 64'hFF0000000000FFFF;
        load_init();
        run_gens(1, 1'b0);
        for (int r = 0; r < 8; r++)
            check("wrap_rows", rbuf[r], (r == 7 || r == 0 || r == 1) ? 64'h00000000000000FF : 64'h0);

        // Random boards with arbitrary nonzero live bytes.
        repeat (4) begin
            random_init();
            run_gens(2, 1'b1);
        end

        // enable dropped mid-scan: generation still completes, then the block goes quiet.
        random_init();
        push_gen();
        @(negedge clk);
        enable = 1'b1;
        found  = 0;
        for (int k = 0; k < 300 && found == 0; k++) begin
            @(negedge clk);
            if (busy && pixel == 6'd20) begin
                enable = 1'b0;
                found  = 1;
            end
        end
        enable = 1'b0;
        check("drop_reached_px20", 64'(found), 64'd1);
        found = 0;
        for (int k = 0; k < 300 && found == 0; k++) begin
            @(negedge clk);
            if (gen_done) found = 1;
        end
        check("drop_gen_done", 64'(found), 64'd1);
        act = 0;
        repeat (20) begin
            @(negedge clk);
            if (write_flag != 2'b00 || busy) act++;
        end
        check("drop_quiet", 64'(act), 64'd0);
        check_rows_model("drop_rows");

        // Reset in EVAL at pixel 40: no REPLACE, read buffer untouched, then a clean restart.
        random_init();
        saved_grid = ref_grid;
        for (int r = 0; r < 8; r++) saved_rows[r] = rbuf[r];
        push_gen();
        @(negedge clk);
        enable = 1'b1;
        found  = 0;
        for (int k = 0; k < 300 && found == 0; k++) begin
            @(negedge clk);
            if (write_flag == 2'b01 && pixel == 6'd40) found = 1;
        end
        check("reset_reached_px40", 64'(found), 64'd1);
        rst    = 1'b1;
        enable = 1'b0;
        #1;
        check("mid_rst_pixel", 64'(pixel), 64'd0);
        check("mid_rst_write_flag", 64'(write_flag), 64'd0);
        check("mid_rst_npv", 64'(new_pixel_value), 64'(DEAD));
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_gen_done", 64'(gen_done), 64'd0);
        check("mid_rst_gen_count", 64'(gen_count), 64'd0);
        sb_q.delete();
        cnt_pending = 1'b0;
        drv_gen     = 16'd0;
        ref_grid    = saved_grid;
        repeat (3) @(negedge clk);
        for (int r = 0; r < 8; r++) check("reset_readbuf_kept", rbuf[r], saved_rows[r]);
        rst = 1'b0;
        run_gens(1, 1'b0);
        check("restart_gen_count", 64'(gen_count), 64'd1);

        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
